// File: rtl/knapsack_pkg.sv
// Shared types and default sizing for the exhaustive 0/1 knapsack solver.
package knapsack_pkg;

  localparam int N_ITEMS_DEF = 5;
  localparam int VW_DEF      = 8;
  localparam int WW_DEF      = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/knapsack_eval.sv
// Combinational subset evaluator: sums value and weight of the items selected by mask_i.
module knapsack_eval
  import knapsack_pkg::*;
#(
  parameter int N_ITEMS = N_ITEMS_DEF,
  parameter int VW      = VW_DEF,
  parameter int WW      = WW_DEF,
  localparam int SVW    = VW + $clog2(N_ITEMS + 1),
  localparam int SWW    = WW + $clog2(N_ITEMS + 1)
) (
  input  logic [N_ITEMS-1:0]    mask_i,
  input  logic [N_ITEMS*VW-1:0] values_i,
  input  logic [N_ITEMS*WW-1:0] weights_i,
  input  logic [WW-1:0]         capacity_i,
  output logic [SVW-1:0]        total_value_o,
  output logic [SWW-1:0]        total_weight_o,
  output logic                  feasible_o
);

  // Sums are widened so that N_ITEMS maximal items can never overflow.
  always_comb begin
    total_value_o  = '0;
    total_weight_o = '0;
    for (int i = 0; i < N_ITEMS; i++) begin
      if (mask_i[i]) begin
        total_value_o  = total_value_o  + SVW'(values_i[i*VW +: VW]);
        total_weight_o = total_weight_o + SWW'(weights_i[i*WW +: WW]);
      end
    end
    feasible_o = (total_weight_o <= SWW'(capacity_i));
  end

endmodule

// File: rtl/knapsack_solver.sv
// Brute-force knapsack solver: scans every subset, one per cycle, keeping the best feasible one.
module knapsack_solver
  import knapsack_pkg::*;
#(
  parameter int N_ITEMS = N_ITEMS_DEF,
  parameter int VW      = VW_DEF,
  parameter int WW      = WW_DEF,
  localparam int SVW    = VW + $clog2(N_ITEMS + 1),
  localparam int SWW    = WW + $clog2(N_ITEMS + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [N_ITEMS*VW-1:0] values,
  input  logic [N_ITEMS*WW-1:0] weights,
  input  logic [WW-1:0]         capacity,
  input  logic [SVW-1:0]        min_value,
  output logic                  busy,
  output logic                  done,
  output logic [SVW-1:0]        best_value,
  output logic [N_ITEMS-1:0]    best_sel,
  output logic                  valid
);

  state_e                state_q, state_d;
  logic [N_ITEMS-1:0]    cnt_q, cnt_d;
  logic [N_ITEMS*VW-1:0] vals_q, vals_d;
  logic [N_ITEMS*WW-1:0] wts_q, wts_d;
  logic [WW-1:0]         cap_q, cap_d;
  logic [SVW-1:0]        min_q, min_d;
  logic [SVW-1:0]        best_val_q, best_val_d;
  logic [N_ITEMS-1:0]    best_sel_q, best_sel_d;
  logic                  valid_q, valid_d;

  logic [SVW-1:0]        tot_value;
  logic [SWW-1:0]        tot_weight;
  logic                  feasible;

  knapsack_eval #(
    .N_ITEMS (N_ITEMS),
    .VW      (VW),
    .WW      (WW)
  ) u_eval (
    .mask_i         (cnt_q),
    .values_i       (vals_q),
    .weights_i      (wts_q),
    .capacity_i     (cap_q),
    .total_value_o  (tot_value),
    .total_weight_o (tot_weight),
    .feasible_o     (feasible)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    vals_d     = vals_q;
    wts_d      = wts_q;
    cap_d      = cap_q;
    min_d      = min_q;
    best_val_d = best_val_q;
    best_sel_d = best_sel_q;
    valid_d    = valid_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d    = ST_SCAN;
          cnt_d      = '0;
          vals_d     = values;
          wts_d      = weights;
          cap_d      = capacity;
          min_d      = min_value;
          best_val_d = '0;
          best_sel_d = '0;
          valid_d    = 1'b0;
        end
      end
      ST_SCAN: begin
        // Strictly-greater keeps the lowest-index subset on value ties.
        if (feasible && (tot_value > best_val_q)) begin
          best_val_d = tot_value;
          best_sel_d = cnt_q;
        end
        if (cnt_q == '1) begin
          state_d = ST_DONE;
          cnt_d   = '0;
          valid_d = (best_val_d >= min_q);
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      vals_q     <= '0;
      wts_q      <= '0;
      cap_q      <= '0;
      min_q      <= '0;
      best_val_q <= '0;
      best_sel_q <= '0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      vals_q     <= vals_d;
      wts_q      <= wts_d;
      cap_q      <= cap_d;
      min_q      <= min_d;
      best_val_q <= best_val_d;
      best_sel_q <= best_sel_d;
      valid_q    <= valid_d;
    end
  end

  assign busy       = (state_q == ST_SCAN);
  assign done       = (state_q == ST_DONE);
  assign best_value = best_val_q;
  assign best_sel   = best_sel_q;
  assign valid      = valid_q;

endmodule

// File: tb/tb_knapsack_solver.sv
// Bench for knapsack_solver: default 5-item instance plus an 8-item saturation instance.
module tb_knapsack_solver;

  localparam int N  = 5;
  localparam int SV = 8 + $clog2(N + 1);
  localparam int N8 = 8;
  localparam int SV8 = 8 + $clog2(N8 + 1);
  localparam int RW = SV + N + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic            start = 1'b0;
  logic [N*8-1:0]  values = '0;
  logic [N*8-1:0]  weights = '0;
  logic [7:0]      capacity = '0;
  logic [SV-1:0]   min_value = '0;
  logic            busy, done, valid;
  logic [SV-1:0]   best_value;
  logic [N-1:0]    best_sel;

  logic            start8 = 1'b0;
  logic [N8*8-1:0] values8 = '0;
  logic [N8*8-1:0] weights8 = '0;
  logic [7:0]      capacity8 = '0;
  logic [SV8-1:0]  min_value8 = '0;
  logic            busy8, done8, valid8;
  logic [SV8-1:0]  best_value8;
  logic [N8-1:0]   best_sel8;

  knapsack_solver dut (
    .clk(clk), .rst(rst), .start(start), .values(values), .weights(weights),
    .capacity(capacity), .min_value(min_value), .busy(busy), .done(done),
    .best_value(best_value), .best_sel(best_sel), .valid(valid)
  );

  knapsack_solver #(.N_ITEMS(N8), .VW(8), .WW(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .values(values8), .weights(weights8),
    .capacity(capacity8), .min_value(min_value8), .busy(busy8), .done(done8),
    .best_value(best_value8), .best_sel(best_sel8), .valid(valid8)
  );

  typedef struct {
    logic [N*8-1:0] vals;
    logic [N*8-1:0] wts;
    logic [7:0]     cap;
    logic [SV-1:0]  minv;
    logic [SV-1:0]  ev;
    logic [N-1:0]   es;
    logic           evalid;
  } vec_t;

  logic [RW-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: exhaustive search, lowest index wins ties.
  function automatic logic [RW-1:0] model(input logic [N*8-1:0] v, input logic [N*8-1:0] w,
                                          input logic [7:0] cap, input logic [SV-1:0] minv);
    int bv = 0;
    int bs = 0;
    for (int m = 0; m < (1 << N); m++) begin
      int sv = 0;
      int sw = 0;
      for (int i = 0; i < N; i++)
        if (m[i]) begin
          sv += int'(v[i*8 +: 8]);
          sw += int'(w[i*8 +: 8]);
        end
      if (sw <= int'(cap) && sv > bv) begin
        bv = sv;
        bs = m;
      end
    end
    return {SV'(bv), N'(bs), (bv >= int'(minv))};
  endfunction

  task automatic solve5(input vec_t v, input bit disturb);
    logic [RW-1:0] e;
    int n = 0;
    bit seen = 0;
    @(negedge clk);
    values = v.vals; weights = v.wts; capacity = v.cap; min_value = v.minv; start = 1'b1;
    exp_q.push_back({v.ev, v.es, v.evalid});
    @(posedge clk); #1;
    if (!disturb) start = 1'b0;
    check("busy_after_start", busy, 1);
    while (n < 40 && !seen) begin
      @(posedge clk); #1;
      n++;
      if (done) seen = 1;
      else if (disturb) begin
        values = {$urandom, $urandom}; weights = {$urandom, $urandom};
        capacity = 8'($urandom); min_value = '0;
      end
    end
    check("done_latency", n, 32);
    check("busy_at_done", busy, 0);
    if (exp_q.size() == 0) begin
      check("scoreboard_nonempty", 0, 1);
    end else begin
      e = exp_q.pop_front();
      check("best_value", best_value, e[RW-1 -: SV]);
      check("best_sel", best_sel, e[N:1]);
      check("valid", valid, e[0]);
    end
    @(posedge clk); #1;
    check("done_one_cycle", done, 0);
    start = 1'b0;
    @(posedge clk); #1;
    check("no_restart", busy, 0);
    check("hold_best_value", best_value, e[RW-1 -: SV]);
  endtask

  vec_t tbl[8];

  initial begin
    int n;
    bit seen;
    logic [RW-1:0] r;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_best_value", best_value, 0);
    check("rst_best_sel", best_sel, 0);
    check("rst_valid", valid, 0);
    check("rst_busy8", busy8, 0);
    @(negedge clk) rst = 1'b0;

    tbl[0] = '{{8'd10,8'd1,8'd2,8'd2,8'd4}, {8'd4,8'd1,8'd2,8'd1,8'd12}, 8'd15, SV'(15), SV'(15), 5'b11110, 1'b1};
    tbl[1] = '{{8'd10,8'd1,8'd2,8'd2,8'd4}, {8'd4,8'd1,8'd2,8'd1,8'd12}, 8'd0,  SV'(1),  SV'(0),  5'b00000, 1'b0};
    tbl[2] = '{{8'd9,8'd9,8'd9,8'd5,8'd5}, {8'd200,8'd200,8'd200,8'd3,8'd3}, 8'd3, SV'(5), SV'(5), 5'b00001, 1'b1};
    tbl[3] = '{{8'd10,8'd1,8'd2,8'd2,8'd4}, {8'd4,8'd1,8'd2,8'd1,8'd12}, 8'd15, SV'(16), SV'(15), 5'b11110, 1'b0};
    for (int i = 4; i < 8; i++) begin
      tbl[i].vals = {$urandom, $urandom};
      tbl[i].wts  = {$urandom, $urandom};
      tbl[i].cap  = 8'($urandom_range(0, 600) > 255 ? 255 : $urandom_range(0, 255));
      tbl[i].minv = SV'($urandom_range(0, 700));
      r = model(tbl[i].vals, tbl[i].wts, tbl[i].cap, tbl[i].minv);
      tbl[i].ev = r[RW-1 -: SV]; tbl[i].es = r[N:1]; tbl[i].evalid = r[0];
    end
    for (int i = 0; i < 8; i++) solve5(tbl[i], 1'b0);

    // Start held high and inputs scrambled mid-scan: latched operands must win.
    solve5(tbl[0], 1'b1);

    // Mid-scan reset aborts without a done pulse.
    @(negedge clk);
    values = tbl[0].vals; weights = tbl[0].wts; capacity = tbl[0].cap; min_value = tbl[0].minv;
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (10) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_best_value", best_value, 0);
    check("abort_best_sel", best_sel, 0);
    check("abort_valid", valid, 0);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done || busy) seen = 1;
    end
    check("abort_no_done", seen, 0);
    solve5(tbl[0], 1'b0);

    // Reset takes priority over start on the same edge.
    @(negedge clk); rst = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    check("rst_over_start", busy, 0);
    rst = 1'b0; start = 1'b0;

    // 8-item saturation: every item 255, capacity admits exactly one.
    @(negedge clk);
    values8 = '1; weights8 = '1; capacity8 = 8'd255; min_value8 = SV8'(255); start8 = 1'b1;
    @(posedge clk); #1 start8 = 1'b0;
    n = 0; seen = 0;
    while (n < 300 && !seen) begin
      @(posedge clk); #1;
      n++;
      if (done8) seen = 1;
    end
    check("done_latency8", n, 256);
    check("best_value8", best_value8, 255);
    check("best_sel8", best_sel8, 8'b00000001);
    check("valid8", valid8, 1);

    check("scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/knapsack_solver.md
KNAPSACK_SOLVER -- requirements
Module: knapsack_solver

Interface
REQ-001 Parameter N_ITEMS, default 5, number of candidate items (2..16).
REQ-002 Parameter VW, default 8, per-item value width in bits.
REQ-003 Parameter WW, default 8, per-item weight and capacity width in bits.
REQ-004 Derived SVW = VW + clog2(N_ITEMS+1) and SWW = WW + clog2(N_ITEMS+1) are sum widths; no sum SHALL overflow.
REQ-005 clk  input  1  single clock; all state updates on its rising edge.
REQ-006 rst  input  1  reset; synchronous and active-high.
REQ-007 start  input  1  request a solve; sampled only in IDLE.
REQ-008 values  input  N_ITEMS*VW  item values, unsigned; item i at bits [i*VW +: VW].
REQ-009 weights  input  N_ITEMS*WW  item weights, unsigned; item i at bits [i*WW +: WW].
REQ-010 capacity  input  WW  maximum total weight, inclusive.
REQ-011 min_value  input  SVW  decision threshold.
REQ-012 busy  output  1  high while a scan is in progress.
REQ-013 done  output  1  one-cycle pulse when results become valid.
REQ-014 best_value  output  SVW  highest feasible total value found.
REQ-015 best_sel  output  N_ITEMS  selection mask for best_value; bit i set = item i taken.
REQ-016 valid  output  1  best_value >= min_value (decision answer).

Function
REQ-017 FSM states: IDLE, SCAN, DONE; IDLE->SCAN on start; SCAN->DONE after the last subset; DONE->IDLE unconditionally next cycle.
REQ-018 On start in IDLE, values, weights, capacity and min_value SHALL be latched; later input changes have no effect until the next start.
REQ-019 In SCAN, a N_ITEMS-bit subset counter steps 0 .. 2^N_ITEMS-1, evaluating exactly one subset per cycle.
REQ-020 Per subset: total value and total weight are unsigned sums of the selected items at widths SVW/SWW.
REQ-021 A subset is feasible iff total weight <= capacity; best SHALL update only when feasible and total value strictly greater than the current best (ties keep the lower subset index).
REQ-022 Best registers SHALL clear to value 0, mask 0 on start; subset 0 is always feasible, so the empty selection is the floor result.
REQ-023 Latency: start sampled at edge t; busy high for cycles t+1 .. t+2^N_ITEMS; done = 1 and busy = 0 at cycle t+2^N_ITEMS+1.
REQ-024 best_value, best_sel and valid SHALL hold from done until the next accepted start; they are not guaranteed stable while busy.
REQ-025 start while busy or in DONE SHALL be ignored (no restart, no queuing).
REQ-026 Counter terminal: scan ends on counter all-ones; the counter SHALL NOT wrap into a second pass.

Reset
REQ-027 rst SHALL force IDLE, counter 0, busy 0, done 0, best_value 0, best_sel 0, valid 0 at the next edge.
REQ-028 rst asserted mid-scan SHALL abort the scan without a done pulse; rst has priority over start on the same edge.

Structure
REQ-029 Package knapsack_pkg SHALL hold the FSM state enum and default parameter constants (N_ITEMS, VW, WW).
REQ-030 Sub-module knapsack_eval SHALL be the combinational subset evaluator (mask, latched items, capacity -> total value, total weight, feasible).

Verification
REQ-031 Defaults; values {4,2,2,1,10}, weights {12,1,2,1,4} (item 0..4), capacity 15, min_value 15, start -> done at t+33, best_value 15, best_sel 5'b11110, valid 1.
REQ-032 Same items, capacity 0, min_value 1 -> best_value 0, best_sel 0, valid 0.
REQ-033 Items 0 and 1 both value 5 weight 3, others weight 200, capacity 3 -> best_sel 5'b00001 (tie keeps lower index), best_value 5.
REQ-034 rst pulsed at t+10 of a scan -> no done pulse, all outputs 0, busy 0; fresh start completes normally.
REQ-035 start re-asserted and inputs changed during scan -> no restart, done at t+33, results match the latched inputs.
REQ-036 N_ITEMS=8, VW=WW=8, all values/weights 255, capacity 255 -> done at t+257, best_value 255, best_sel 8'b00000001, no overflow.
